// File: rtl/a_chan_assembler_if.sv
// A-channel beat input and assembled-message valid/ready output.
// master = producer/consumer side, slave = assembler side.
interface a_chan_assembler_if;
  logic        a_valid;
  logic [3:0]  a_opcode;
  logic [1:0]  a_beat;
  logic [7:0]  a_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_opcode;
  logic [2:0]  m_len;
  logic [31:0] m_data;

  modport master (
    output a_valid, a_opcode, a_beat, a_data, m_ready,
    input  m_valid, m_opcode, m_len, m_data
  );

  modport slave (
    input  a_valid, a_opcode, a_beat, a_data, m_ready,
    output m_valid, m_opcode, m_len, m_data
  );
endinterface

// File: rtl/a_chan_assembler.sv
// Gathers 1-4 byte beats into 32-bit messages and queues them in a small FIFO.
// The A channel cannot be stalled, so bad beats and full-FIFO drops are only counted.
module a_chan_assembler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  a_chan_assembler_if.slave bus,
  output logic [CNT_W-1:0] err_seq_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  lat_opcode, lat_opcode_nxt;
  logic [1:0]  expect_idx, expect_nxt;
  logic [31:0] part_data, part_nxt;
  logic [31:0] merged;
  logic        start;
  logic        push;
  logic        seq_err;
  logic [3:0]  push_opcode;
  logic [31:0] push_data;

  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [3:0]     fifo_opcode [DEPTH];
  logic [31:0]    fifo_data   [DEPTH];
  logic           empty, full, pop, accept, drop;
  logic [3:0]     head_opcode;
  logic [31:0]    head_data;

  always_comb begin
    merged = part_data;
    case (expect_idx)
      2'd0: merged[7:0]   = bus.a_data;
      2'd1: merged[15:8]  = bus.a_data;
      2'd2: merged[23:16] = bus.a_data;
      default: merged[31:24] = bus.a_data;
    endcase
  end

  // A beat 0 always starts a fresh message, even when it interrupts a partial one.
  always_comb begin
    state_nxt      = state;
    lat_opcode_nxt = lat_opcode;
    expect_nxt     = expect_idx;
    part_nxt       = part_data;
    start          = 1'b0;
    push           = 1'b0;
    seq_err        = 1'b0;
    push_opcode    = lat_opcode;
    push_data      = part_data;
    if (bus.a_valid) begin
      if (state == IDLE) begin
        if (bus.a_beat == 2'd0) start = 1'b1;
        else                    seq_err = 1'b1;
      end else if (bus.a_beat == expect_idx && bus.a_opcode == lat_opcode) begin
        part_nxt = merged;
        if (expect_idx == lat_opcode[3:2]) begin
          push      = 1'b1;
          push_data = merged;
          state_nxt = IDLE;
        end else begin
          expect_nxt = expect_idx + 2'd1;
        end
      end else begin
        seq_err   = 1'b1;
        state_nxt = IDLE;
        if (bus.a_beat == 2'd0) start = 1'b1;
      end
      if (start) begin
        lat_opcode_nxt = bus.a_opcode;
        part_nxt       = {24'd0, bus.a_data};
        expect_nxt     = 2'd1;
        if (bus.a_opcode[3:2] == 2'd0) begin
          push        = 1'b1;
          push_opcode = bus.a_opcode;
          push_data   = {24'd0, bus.a_data};
          state_nxt   = IDLE;
        end else begin
          state_nxt = COLLECT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_opcode <= 4'd0;
      expect_idx <= 2'd0;
      part_data  <= 32'd0;
    end else begin
      state      <= state_nxt;
      lat_opcode <= lat_opcode_nxt;
      expect_idx <= expect_nxt;
      part_data  <= part_nxt;
    end
  end

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop    = !empty && bus.m_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && !accept;

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_opcode[wr_ptr[PTR_W-1:0]] <= push_opcode;
      fifo_data[wr_ptr[PTR_W-1:0]]   <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err_seq_count <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      if (seq_err && err_seq_count != '1) err_seq_count <= err_seq_count + CNT_ONE;
      if (drop && drop_count != '1)       drop_count    <= drop_count + CNT_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  // Head fields are forced to zero while the FIFO is empty.
  assign head_opcode  = fifo_opcode[rd_ptr[PTR_W-1:0]];
  assign head_data    = fifo_data[rd_ptr[PTR_W-1:0]];
  assign bus.m_valid  = !empty;
  assign bus.m_opcode = empty ? 4'd0  : head_opcode;
  assign bus.m_len    = empty ? 3'd0  : ({1'b0, head_opcode[3:2]} + 3'd1);
  assign bus.m_data   = empty ? 32'd0 : head_data;

endmodule

// File: tb/tb_a_chan_assembler.sv
// Bench for a_chan_assembler: vector table plus hand sequences, with a message
// scoreboard popped whenever the DUT hands a message to the consumer.
module tb_a_chan_assembler;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] err_seq_count;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  a_chan_assembler_if bus ();

  a_chan_assembler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .err_seq_count (err_seq_count),
    .drop_count    (drop_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opcode;
    logic [2:0]  len;
    logic [31:0] data;
  } msg_t;

  typedef struct {
    logic [3:0]  opcode;
    logic [31:0] payload;
    logic [2:0]  exp_len;
    logic [31:0] exp_data;
  } vec_t;

  msg_t sb[$];
  msg_t exp_msg;
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] opc, input logic [1:0] beat,
                               input logic [7:0] data);
    bus.a_valid  = 1'b1;
    bus.a_opcode = opc;
    bus.a_beat   = beat;
    bus.a_data   = data;
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendMessage(input logic [3:0] opc, input logic [31:0] payload,
                             input int gap);
    int beats;
    beats = int'(opc[3:2]) + 1;
    for (int k = 0; k < beats; k++) begin
      if (k > 0 && gap > 0) idleCycles(gap);
      applyStimulus(opc, 2'(k), payload[8*k +: 8]);
    end
  endtask

  task automatic expectMsg(input logic [3:0] opc, input logic [2:0] len,
                           input logic [31:0] data);
    msg_t m;
    m.opcode = opc;
    m.len    = len;
    m.data   = data;
    sb.push_back(m);
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_m_valid"},  32'(bus.m_valid),  32'd0);
    checkOutput({tag, "_m_opcode"}, 32'(bus.m_opcode), 32'd0);
    checkOutput({tag, "_m_len"},    32'(bus.m_len),    32'd0);
    checkOutput({tag, "_m_data"},   bus.m_data,        32'd0);
    checkOutput({tag, "_err"},      32'(err_seq_count), 32'd0);
    checkOutput({tag, "_drop"},     32'(drop_count),   32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow),     32'd0);
  endtask

  // Every accepted handshake must match the oldest expected message.
  always @(negedge clk) begin
    if (!reset && bus.m_valid && bus.m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got opcode 0x%0h data 0x%0h, expected no message",
                 bus.m_opcode, bus.m_data);
      end else begin
        exp_msg = sb.pop_front();
        checkOutput("sb_opcode", 32'(bus.m_opcode), 32'(exp_msg.opcode));
        checkOutput("sb_len",    32'(bus.m_len),    32'(exp_msg.len));
        checkOutput("sb_data",   bus.m_data,        exp_msg.data);
      end
    end
  end

  initial begin
    vecs[0] = '{opcode: 4'h0, payload: 32'hFFFF_FF77, exp_len: 3'd1, exp_data: 32'h0000_0077};
    vecs[1] = '{opcode: 4'h5, payload: 32'hAAAA_BEEF, exp_len: 3'd2, exp_data: 32'h0000_BEEF};
    vecs[2] = '{opcode: 4'hA, payload: 32'h9912_3456, exp_len: 3'd3, exp_data: 32'h0012_3456};
    vecs[3] = '{opcode: 4'hF, payload: 32'hDEAD_BEEF, exp_len: 3'd4, exp_data: 32'hDEAD_BEEF};
    vecs[4] = '{opcode: 4'h3, payload: 32'h1234_56FF, exp_len: 3'd1, exp_data: 32'h0000_00FF};
    vecs[5] = '{opcode: 4'h6, payload: 32'h5555_8001, exp_len: 3'd2, exp_data: 32'h0000_8001};

    reset        = 1'b1;
    bus.a_valid  = 1'b0;
    bus.a_opcode = 4'd0;
    bus.a_beat   = 2'd0;
    bus.a_data   = 8'd0;
    bus.m_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkCleared("reset");

    // Single beat: visible the cycle after the beat is sampled.
    expectMsg(4'h1, 3'd1, 32'h0000_00A5);
    applyStimulus(4'h1, 2'd0, 8'hA5);
    checkOutput("single_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("single_data",  bus.m_data,       32'h0000_00A5);
    checkOutput("single_len",   32'(bus.m_len),   32'd1);
    checkOutput("single_err",   32'(err_seq_count), 32'd0);

    // Four beats with idle gaps.
    expectMsg(4'hC, 3'd4, 32'h4433_2211);
    applyStimulus(4'hC, 2'd0, 8'h11);
    idleCycles(2);
    applyStimulus(4'hC, 2'd1, 8'h22);
    idleCycles(1);
    applyStimulus(4'hC, 2'd2, 8'h33);
    idleCycles(3);
    checkOutput("four_partial_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(4'hC, 2'd3, 8'h44);
    checkOutput("four_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("four_data",  bus.m_data,       32'h4433_2211);

    for (int i = 0; i < 6; i++) begin
      expectMsg(vecs[i].opcode, vecs[i].exp_len, vecs[i].exp_data);
      sendMessage(vecs[i].opcode, vecs[i].payload, i % 2);
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.m_valid), 32'd1);
      checkOutput($sformatf("vec%0d_len", i),   32'(bus.m_len),   32'(vecs[i].exp_len));
      checkOutput($sformatf("vec%0d_data", i),  bus.m_data,       vecs[i].exp_data);
    end
    idleCycles(1);

    // Sequence errors: restart on beat 0, stray beat, opcode change, 1-beat restart.
    expectMsg(4'h8, 3'd3, 32'h00DD_CCBB);
    applyStimulus(4'h8, 2'd0, 8'hAA);
    applyStimulus(4'h8, 2'd0, 8'hBB);
    checkOutput("restart_err",   32'(err_seq_count), 32'd1);
    checkOutput("restart_valid", 32'(bus.m_valid),   32'd0);
    applyStimulus(4'h8, 2'd1, 8'hCC);
    checkOutput("restart_partial_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(4'h8, 2'd2, 8'hDD);
    checkOutput("restart_data", bus.m_data, 32'h00DD_CCBB);
    idleCycles(1);
    applyStimulus(4'h8, 2'd2, 8'hEE);
    checkOutput("stray_err",   32'(err_seq_count), 32'd2);
    checkOutput("stray_valid", 32'(bus.m_valid),   32'd0);
    applyStimulus(4'h4, 2'd0, 8'h11);
    applyStimulus(4'h5, 2'd1, 8'h22);
    checkOutput("opc_mismatch_err", 32'(err_seq_count), 32'd3);
    applyStimulus(4'h4, 2'd1, 8'h33);
    checkOutput("after_abort_err",   32'(err_seq_count), 32'd4);
    checkOutput("after_abort_valid", 32'(bus.m_valid),   32'd0);
    applyStimulus(4'h8, 2'd0, 8'h77);
    expectMsg(4'h1, 3'd1, 32'h0000_005A);
    applyStimulus(4'h1, 2'd0, 8'h5A);
    checkOutput("restart1_err",  32'(err_seq_count), 32'd5);
    checkOutput("restart1_data", bus.m_data,         32'h0000_005A);
    idleCycles(1);
    waitDrain(10);

    // Overflow: six messages into a four-entry FIFO with no consumer.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expectMsg(4'h2, 3'd1, 32'h10 + 32'(i));
      applyStimulus(4'h2, 2'd0, 8'(8'h10 + i));
    end
    checkOutput("ovf_drop",     32'(drop_count), 32'd2);
    checkOutput("ovf_overflow", 32'(overflow),   32'd1);
    checkOutput("ovf_head",     bus.m_data,      32'h0000_0010);
    idleCycles(2);
    checkOutput("ovf_head_stable", bus.m_data,         32'h0000_0010);
    checkOutput("ovf_err_kept",    32'(err_seq_count), 32'd5);
    bus.m_ready = 1'b1;
    waitDrain(20);
    idleCycles(1);
    checkOutput("ovf_drained_valid", 32'(bus.m_valid), 32'd0);

    // Full FIFO with a pop in the completion cycle: no drop.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expectMsg(4'h2, 3'd1, 32'h20 + 32'(i));
      applyStimulus(4'h2, 2'd0, 8'(8'h20 + i));
    end
    applyStimulus(4'h4, 2'd0, 8'h31);
    bus.m_ready = 1'b1;
    expectMsg(4'h4, 3'd2, 32'h0000_3231);
    applyStimulus(4'h4, 2'd1, 8'h32);
    bus.m_ready = 1'b0;
    checkOutput("fullpop_drop", 32'(drop_count), 32'd2);
    checkOutput("fullpop_head", bus.m_data,      32'h0000_0021);
    applyStimulus(4'h2, 2'd0, 8'h99);
    checkOutput("fullpop_still_full_drop", 32'(drop_count), 32'd3);
    bus.m_ready = 1'b1;
    waitDrain(20);
    idleCycles(1);

    // Reset in the middle of a 3-beat message.
    applyStimulus(4'h8, 2'd0, 8'hE1);
    applyStimulus(4'h8, 2'd1, 8'hE2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkCleared("midreset");
    idleCycles(3);
    checkOutput("midreset_no_push", 32'(bus.m_valid), 32'd0);
    expectMsg(4'h4, 3'd2, 32'h0000_0201);
    applyStimulus(4'h4, 2'd0, 8'h01);
    applyStimulus(4'h4, 2'd1, 8'h02);
    checkOutput("post_reset_data", bus.m_data,         32'h0000_0201);
    checkOutput("post_reset_err",  32'(err_seq_count), 32'd0);
    waitDrain(10);
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
